andor_bist: RTL and testbench
=============================

Name: andor_bist

Overview:
- Synthesizable self-test engine for the 2-bit AND/OR block.
- Drives every X/Y operand pair into the AND/OR block. For each pair it samples the block's XandY and XorY results and compares them with the expected values.
- Reports an error count, the first failing vector and a pass/done status.
- Sits beside the AND/OR block in the lab top level and replaces the simulation-only tester for on-board checks.

Parameters:
- WIDTH, 2, operand width of X and Y.
- SETTLE, 1, cycles between applying a vector and sampling the results. Legal range is 1..15; values below 1 are illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a test run; sampled only in IDLE or DONE
- x_out  output  WIDTH  X operand to the block under test; registered
- y_out  output  WIDTH  Y operand to the block under test; registered
- and_in  input  WIDTH  XandY result from the block under test
- or_in  input  WIDTH  XorY result from the block under test
- busy  output  1  high while a run is in progress (WAIT or CHECK)
- done  output  1  high while in DONE
- pass  output  1  equals done AND (err_count == 0)
- err_count  output  2*WIDTH+1  number of failing vectors in the last run
- first_fail  output  2*WIDTH  index of the first failing vector, as {x,y}
- fail_seen  output  1  high once any vector of the current run has failed

Behaviour:
- Reset: rst_n low at a rising edge resets the block whatever its state, including mid-run. After that edge:
  - state = IDLE
  - x_out = 0, y_out = 0
  - busy = 0, done = 0, pass = 0
  - err_count = 0, first_fail = 0, fail_seen = 0
  - vector counter = 0, settle counter = 0
- Vector counter vec: 2*WIDTH bits. x_out = vec[2W-1:W], y_out = vec[W-1:0], both registered from vec. Vectors run 0 to 2^(2W)-1 in ascending order; there are 16 vectors at the default width.
- Expected results: exp_and = x_out & y_out, exp_or = x_out | y_out, both bitwise.
  - A vector fails if (and_in != exp_and) OR (or_in != exp_or).
  - Each failing vector counts once, even if both outputs mismatch.
- States:
  - IDLE: outputs hold. start=1 -> go to WAIT; vec=0; settle counter=SETTLE-1; err_count, first_fail and fail_seen cleared; busy=1.
  - WAIT: settle counter==0 -> go to CHECK; otherwise decrement. Operands stay stable.
  - CHECK: one cycle. Compare at the clock edge using the current inputs.
    - On failure: err_count+1.
    - On the first failure of the run: first_fail=vec and fail_seen=1.
    - If vec is the last vector -> go to DONE; busy=0; done=1; vec holds.
    - Otherwise vec+1, settle counter reloads, go to WAIT.
  - DONE: done, pass and results hold until the next start or reset. start=1 behaves exactly as from IDLE (done=0, results cleared).
- start is ignored while busy; it is not queued.
- Timing: each vector takes SETTLE+1 cycles.
  - With start sampled at edge E0, done rises after edge E(2^(2W)*(SETTLE+1)).
  - At the defaults that is E32.
- err_count never wraps: its maximum of 2^(2W) fits in 2W+1 bits.
- and_in and or_in are used only in CHECK. Glitches during WAIT have no effect.

Test Plan:
- Correct AND/OR block connected, defaults, start pulse at E0 -> done=1 after E32; pass=1; err_count=0; fail_seen=0; x_out,y_out sweep 00/00..11/11.
- or_in tied to 0 -> 15 failures: err_count=15, first_fail=4'b0001, pass=0, done=1.
- and_in bit0 inverted -> all 16 vectors fail: err_count=16, first_fail=0. or_in also wrong on vector 5 -> err_count still 16.
- Pulse start again at cycle 10 of a run -> ignored: done still after E32 and vec sequence unbroken. start in DONE -> results cleared, new run completes after 32 more cycles.
- rst_n low at cycle 12 of a run, with errors already counted -> next cycle: IDLE, busy=0, err_count=0, x_out=y_out=0. Later start -> full fresh run.
- SETTLE=3 with a correct block -> done after E64; inputs sampled only on CHECK cycles. Glitch injected on and_in during WAIT -> no error counted.

Source files
------------

// File: rtl/andor_bist.sv
// andor_bist: self-test engine that sweeps all X/Y operand pairs through the AND/OR block
// and counts vectors whose XandY/XorY results disagree with the expected values.
module andor_bist #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     x_out,
    output logic [WIDTH-1:0]     y_out,
    input  logic [WIDTH-1:0]     and_in,
    input  logic [WIDTH-1:0]     or_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   first_fail,
    output logic                 fail_seen
);
    localparam int VW = 2 * WIDTH;
    localparam logic [VW-1:0] LAST = '1;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} stateT;

    stateT state, stateNext;
    logic [VW-1:0] vec, vecNext;
    logic [3:0] settleCnt;
    logic launch, lastVec, vecFail, checkFail;

    assign launch    = (state == IDLE || state == DONE) && start;
    assign lastVec   = vec == LAST;
    assign vecFail   = (and_in != (x_out & y_out)) || (or_in != (x_out | y_out));
    assign checkFail = state == CHECK && vecFail;
    // operands are registered from the next vector so they always match vec
    assign vecNext   = launch ? '0 : (state == CHECK && !lastVec) ? vec + 1'b1 : vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            x_out      <= '0;
            y_out      <= '0;
            settleCnt  <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            state      <= stateNext;
            vec        <= vecNext;
            x_out      <= vecNext[VW-1:WIDTH];
            y_out      <= vecNext[WIDTH-1:0];
            settleCnt  <= (launch || state == CHECK) ? SETTLE_LOAD :
                          (state == WAIT && settleCnt != 0) ? settleCnt - 1'b1 : settleCnt;
            err_count  <= launch ? '0 : checkFail ? err_count + 1'b1 : err_count;
            first_fail <= launch ? '0 : (checkFail && !fail_seen) ? vec : first_fail;
            fail_seen  <= launch ? 1'b0 : fail_seen | checkFail;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: stateNext = start ? WAIT : state;
            WAIT:       stateNext = settleCnt == 0 ? CHECK : WAIT;
            CHECK:      stateNext = lastVec ? DONE : WAIT;
            default:    stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy = state == WAIT || state == CHECK;
        done = state == DONE;
        pass = done && err_count == '0;
    end
endmodule

// File: tb/tb_andor_bist.sv
// tb_andor_bist: exercises andor_bist against a table-driven faulty AND/OR block
// and predicts the run outcome from the fault table.
module tb_andor_bist;
    localparam int W = 2;
    localparam int NV = 1 << (2 * W);

    logic clk = 0, rst_n = 0, start = 0, start3 = 0;
    always #5 clk = ~clk;

    logic [W-1:0] x1, y1, x3, y3, and1, or1, and3, or3;
    logic busy1, done1, pass1, fs1, busy3, done3, pass3, fs3;
    logic [2*W:0] ec1, ec3;
    logic [2*W-1:0] ff1, ff3;

    // per-vector XOR error masks applied to the ideal AND/OR results
    logic [W-1:0] andXor[NV], orXor[NV];
    logic glitch = 0;
    logic [W-1:0] glitchVal = 0;
    always @(negedge clk) glitchVal = W'($urandom);

    assign and1 = (x1 & y1) ^ andXor[{x1, y1}];
    assign or1  = (x1 | y1) ^ orXor[{x1, y1}];
    assign and3 = glitch ? glitchVal : (x3 & y3) ^ andXor[{x3, y3}];
    assign or3  = (x3 | y3) ^ orXor[{x3, y3}];

    andor_bist #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_out(x1), .y_out(y1),
        .and_in(and1), .or_in(or1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .first_fail(ff1), .fail_seen(fs1)
    );

    andor_bist #(.WIDTH(W), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .x_out(x3), .y_out(y3),
        .and_in(and3), .or_in(or3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(ec3), .first_fail(ff3), .fail_seen(fs3)
    );

    logic sel3 = 0;
    logic [W-1:0] xs, ys;
    logic bs, ds, ps, fss;
    logic [2*W:0] ecs;
    logic [2*W-1:0] ffs;
    always_comb begin
        xs  = sel3 ? x3 : x1;
        ys  = sel3 ? y3 : y1;
        bs  = sel3 ? busy3 : busy1;
        ds  = sel3 ? done3 : done1;
        ps  = sel3 ? pass3 : pass1;
        fss = sel3 ? fs3 : fs1;
        ecs = sel3 ? ec3 : ec1;
        ffs = sel3 ? ff3 : ff1;
    end

    int nVectors = 0, nMiscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit bad(input int v);
        return andXor[v] != 0 || orXor[v] != 0;
    endfunction

    task automatic setTables(input int mode);
        for (int v = 0; v < NV; v++) begin
            logic [2*W-1:0] vv;
            vv = (2*W)'(v);
            andXor[v] = mode == 2 || mode == 3 ? W'(1) :
                        mode == 4 ? (($urandom_range(0, 3) == 0) ? W'($urandom) : '0) : '0;
            orXor[v]  = mode == 1 ? vv[2*W-1:W] | vv[W-1:0] :
                        mode == 3 && v == 5 ? W'(1) :
                        mode == 4 ? (($urandom_range(0, 3) == 0) ? W'($urandom) : '0) : '0;
        end
    endtask

    task automatic checkIdleReset(input string name);
        check({name, " busy"}, bs, 0);
        check({name, " done"}, ds, 0);
        check({name, " pass"}, ps, 0);
        check({name, " err"}, ecs, 0);
        check({name, " first"}, ffs, 0);
        check({name, " seen"}, fss, 0);
        check({name, " xy"}, {xs, ys}, 0);
    endtask

    task automatic runTest(input bit use3, input int extraStartAt, input int resetAt, input string name);
        int s, n, expErr, expFirst;
        bit seen;
        s = use3 ? 3 : 1;
        n = NV * (s + 1);
        expErr = 0; expFirst = 0; seen = 0;
        for (int v = 0; v < NV; v++)
            if (bad(v)) begin
                if (!seen) expFirst = v;
                seen = 1;
                expErr++;
            end
        sel3 = use3;
        @(negedge clk);
        if (use3) start3 = 1; else start = 1;
        @(posedge clk); #1;
        start = 0; start3 = 0;
        for (int k = 0; k < n; k++) begin
            check({name, " xy"}, {xs, ys}, k / (s + 1));
            check({name, " busy"}, bs, 1);
            check({name, " done"}, ds, 0);
            if (k == resetAt) begin
                int part;
                part = 0;
                for (int v = 0; v < NV; v++)
                    if ((v + 1) * (s + 1) <= k && bad(v)) part++;
                check({name, " partial err"}, ecs, part);
                rst_n = 0;
                @(posedge clk); #1;
                rst_n = 1;
                checkIdleReset({name, " after reset"});
                return;
            end
            if (use3) start3 = k == extraStartAt; else start = k == extraStartAt;
            glitch = use3 && (k % (s + 1) != s);
            @(posedge clk); #1;
        end
        start = 0; start3 = 0; glitch = 0;
        check({name, " done"}, ds, 1);
        check({name, " busy"}, bs, 0);
        check({name, " pass"}, ps, expErr == 0);
        check({name, " err"}, ecs, expErr);
        check({name, " first"}, ffs, expFirst);
        check({name, " seen"}, fss, seen);
        repeat (3) @(posedge clk);
        #1;
        check({name, " hold done"}, ds, 1);
        check({name, " hold err"}, ecs, expErr);
    endtask

    initial begin
        setTables(0);
        repeat (2) @(posedge clk);
        #1;
        checkIdleReset("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        checkIdleReset("idle");
        runTest(0, -1, -1, "clean");
        setTables(1);
        runTest(0, -1, -1, "or_zero");
        setTables(2);
        runTest(0, -1, -1, "and_bit0");
        setTables(3);
        runTest(0, -1, -1, "and_bit0_or5");
        setTables(0);
        runTest(0, 10, -1, "restart_ignored");
        setTables(2);
        runTest(0, -1, 12, "mid_reset");
        setTables(0);
        runTest(0, -1, -1, "fresh");
        for (int i = 0; i < 4; i++) begin
            setTables(4);
            runTest(0, -1, -1, "random");
        end
        setTables(0);
        runTest(1, -1, -1, "settle3_glitch");
        setTables(4);
        runTest(1, -1, -1, "settle3_random");
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
